sdrc_bist_gen: RTL and testbench

Synthesizable traffic generator and checker for the `sdrc_core` application interface. It performs a programmed sequence of burst writes and read-backs, each write immediately followed by its read, using pseudo-random data. It compares read data in hardware and reports pass/fail, error count and first failing address. It sits beside the application master on the `app_*` port, for silicon bring-up and for regression without a behavioural bench driver.

---
 rtl/sdrc_bist_pkg.sv | 23 ++
 rtl/sdrc_bist_lfsr.sv | 57 +++++
 rtl/sdrc_bist_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_sdrc_bist_gen.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_bist_pkg.sv
// Shared types and LFSR helpers for the sdrc_core BIST traffic generator.
package sdrc_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_NEXT,
        ST_FIN
    } bist_state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/sdrc_bist_lfsr.sv
// Loadable LFSR whose registered output word is the LFSR state replicated per
// 32-bit lane, each lane XORed with its lane index.
module sdrc_bist_lfsr
    import sdrc_bist_pkg::*;
#(
    parameter int APP_DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [31:0]       seed_i,
    input  logic              adv_i,
    input  logic              flip_i,
    output logic [APP_DW-1:0] word_o
);

    localparam int NUM_LANES = APP_DW / 32;

    logic [31:0]       state_q, state_d;
    logic [APP_DW-1:0] word_q, word_d;

    function automatic logic [APP_DW-1:0] replicate(input logic [31:0] v);
        logic [APP_DW-1:0] r;
        for (int k = 0; k < NUM_LANES; k++) begin
            r[32*k +: 32] = v ^ 32'(k);
        end
        return r;
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        if (load_i) begin
            state_d = (seed_i == 32'd0) ? LFSR_ZERO_SEED : seed_i;
        end else if (adv_i) begin
            state_d = lfsr_next(state_q);
        end
        if (load_i || adv_i) begin
            word_d = replicate(state_d) ^ APP_DW'(flip_i);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/sdrc_bist_gen.sv
// Write/read-back BIST traffic generator and checker for the sdrc_core app port.
// Optional SDRC_BIST_ERR_INJ_EN adds err_inject, a single-shot bit-0 flip of the next written word.
module sdrc_bist_gen
    import sdrc_bist_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int ERR_CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
`ifdef SDRC_BIST_ERR_INJ_EN
    input  logic                err_inject,
`endif
    input  logic [APP_AW-1:0]   cfg_base_addr,
    input  logic [APP_AW-1:0]   cfg_stride,
    input  logic [8:0]          cfg_len,
    input  logic [15:0]         cfg_num_bursts,
    input  logic [31:0]         cfg_seed,
    input  logic                sdr_init_done,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_CW-1:0]   err_cnt,
    output logic [APP_AW-1:0]   first_err_addr,
    output logic                app_req,
    output logic                app_req_wr_n,
    output logic [APP_AW-1:0]   app_req_addr,
    output logic [8:0]          app_req_len,
    input  logic                app_req_ack,
    output logic [APP_DW-1:0]   app_wr_data,
    output logic [APP_DW/8-1:0] app_wr_en_n,
    input  logic                app_wr_next_req,
    input  logic                app_rd_valid,
    input  logic [APP_DW-1:0]   app_rd_data
);

    bist_state_e         state_q, state_d;
    logic [APP_AW-1:0]   addr_q, addr_d, stride_q, stride_d, first_err_q, first_err_d;
    logic [8:0]          len_q, len_d, w_q, w_d;
    logic [15:0]         num_q, num_d, b_q, b_d;
    logic [31:0]         seed_q, seed_d, load_seed;
    logic [ERR_CW-1:0]   err_cnt_q, err_cnt_d;
    logic                done_q, done_d, pass_q, pass_d, busy_q, busy_d;
    logic                req_q, req_d, req_wr_n_q, req_wr_n_d;
    logic [APP_DW/8-1:0] wr_en_n_q, wr_en_n_d;
    logic                last_word, wr_load, wr_adv, rd_load, rd_adv, wr_flip;
    logic [APP_DW-1:0]   wr_word, rd_word;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    assign last_word = (w_q == len_q - 9'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = (cfg_num_bursts == 16'd0) ? ST_FIN : ST_WAIT_INIT;
            ST_WAIT_INIT: if (sdr_init_done) state_d = ST_WR_REQ;
            ST_WR_REQ:    if (app_req_ack) state_d = ST_WR_DATA;
            ST_WR_DATA:   if (app_wr_next_req && last_word) state_d = ST_RD_REQ;
            ST_RD_REQ:    if (app_req_ack) state_d = ST_RD_DATA;
            ST_RD_DATA:   if (app_rd_valid && last_word) state_d = ST_NEXT;
            ST_NEXT:      state_d = (b_q + 16'd1 == num_q) ? ST_FIN : ST_WR_REQ;
            ST_FIN:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Generators load one cycle ahead so data is valid from request-state entry.
    assign wr_load   = (state_d == ST_WR_REQ) && (state_q != ST_WR_REQ);
    assign rd_load   = (state_d == ST_RD_REQ) && (state_q != ST_RD_REQ);
    assign wr_adv    = (state_q == ST_WR_DATA) && app_wr_next_req;
    assign rd_adv    = (state_q == ST_RD_DATA) && app_rd_valid;
    assign load_seed = seed_q ^ {16'd0, b_d};

    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        first_err_d = first_err_q;
        len_d       = len_q;
        w_d         = w_q;
        num_d       = num_q;
        b_d         = b_q;
        seed_d      = seed_q;
        err_cnt_d   = err_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        busy_d      = (state_d != ST_IDLE);
        req_d       = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        req_wr_n_d  = (state_d != ST_WR_REQ);
        wr_en_n_d   = ((state_d == ST_WR_REQ) || (state_d == ST_WR_DATA)) ? '0 : '1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = cfg_base_addr;
                    stride_d    = cfg_stride;
                    len_d       = (cfg_len == 9'd0) ? 9'd1 : cfg_len;
                    num_d       = cfg_num_bursts;
                    seed_d      = cfg_seed;
                    b_d         = 16'd0;
                    w_d         = 9'd0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            ST_WR_DATA: if (wr_adv) w_d = last_word ? 9'd0 : w_q + 9'd1;
            ST_RD_DATA: begin
                if (rd_adv) begin
                    w_d = last_word ? 9'd0 : w_q + 9'd1;
                    if (app_rd_data != rd_word) begin
                        if (err_cnt_q == '0) first_err_d = addr_q + APP_AW'(w_q);
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                b_d    = b_q + 16'd1;
                addr_d = addr_q + stride_q;
            end
            ST_FIN: begin
                done_d = 1'b1;
                pass_d = (err_cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            stride_q    <= '0;
            first_err_q <= '0;
            len_q       <= '0;
            w_q         <= '0;
            num_q       <= '0;
            b_q         <= '0;
            seed_q      <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            req_wr_n_q  <= 1'b1;
            wr_en_n_q   <= '1;
        end else begin
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            first_err_q <= first_err_d;
            len_q       <= len_d;
            w_q         <= w_d;
            num_q       <= num_d;
            b_q         <= b_d;
            seed_q      <= seed_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            req_q       <= req_d;
            req_wr_n_q  <= req_wr_n_d;
            wr_en_n_q   <= wr_en_n_d;
        end
    end

`ifdef SDRC_BIST_ERR_INJ_EN
    logic inj_arm_q, inj_arm_d;

    // The flip is consumed only by a word that will actually be written.
    assign wr_flip = inj_arm_q && (wr_load || (wr_adv && !last_word));

    always_comb begin
        inj_arm_d = inj_arm_q;
        if (wr_flip)    inj_arm_d = 1'b0;
        if (err_inject) inj_arm_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) inj_arm_q <= 1'b0;
        else          inj_arm_q <= inj_arm_d;
    end
`else
    assign wr_flip = 1'b0;
`endif

    sdrc_bist_lfsr #(.APP_DW(APP_DW)) u_wr_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (wr_load),
        .seed_i  (load_seed),
        .adv_i   (wr_adv),
        .flip_i  (wr_flip),
        .word_o  (wr_word)
    );

    sdrc_bist_lfsr #(.APP_DW(APP_DW)) u_rd_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (rd_load),
        .seed_i  (load_seed),
        .adv_i   (rd_adv),
        .flip_i  (1'b0),
        .word_o  (rd_word)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign app_req        = req_q;
    assign app_req_wr_n   = req_wr_n_q;
    assign app_req_addr   = addr_q;
    assign app_req_len    = len_q;
    assign app_wr_data    = wr_word;
    assign app_wr_en_n    = wr_en_n_q;

endmodule

// File: tb/tb_sdrc_bist_gen.sv
// Directed bench for sdrc_bist_gen with a simple app-port memory responder.
module tb_sdrc_bist_gen;

    localparam int APP_AW = 26;
    localparam int APP_DW = 32;
    localparam int ERR_CW = 16;

    logic                clk, reset_n, start;
    logic [APP_AW-1:0]   cfg_base_addr, cfg_stride;
    logic [8:0]          cfg_len;
    logic [15:0]         cfg_num_bursts;
    logic [31:0]         cfg_seed;
    logic                sdr_init_done;
    logic                busy, done, pass;
    logic [ERR_CW-1:0]   err_cnt;
    logic [APP_AW-1:0]   first_err_addr;
    logic                app_req, app_req_wr_n;
    logic [APP_AW-1:0]   app_req_addr;
    logic [8:0]          app_req_len;
    logic                app_req_ack;
    logic [APP_DW-1:0]   app_wr_data;
    logic [APP_DW/8-1:0] app_wr_en_n;
    logic                app_wr_next_req, app_rd_valid;
    logic [APP_DW-1:0]   app_rd_data;
    logic                err_inject;

    sdrc_bist_gen #(.APP_AW(APP_AW), .APP_DW(APP_DW), .ERR_CW(ERR_CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
`ifdef SDRC_BIST_ERR_INJ_EN
        .err_inject      (err_inject),
`endif
        .cfg_base_addr   (cfg_base_addr),
        .cfg_stride      (cfg_stride),
        .cfg_len         (cfg_len),
        .cfg_num_bursts  (cfg_num_bursts),
        .cfg_seed        (cfg_seed),
        .sdr_init_done   (sdr_init_done),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_addr  (first_err_addr),
        .app_req         (app_req),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_ack     (app_req_ack),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_valid    (app_rd_valid),
        .app_rd_data     (app_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Responder state: memory image, request log and read-corruption control.
    logic [APP_DW-1:0] mem [logic [APP_AW-1:0]];
    int req_addr[$];
    int req_len[$];
    int req_wr[$];
    int corrupt_burst = -1;
    int corrupt_word  = 0;
    int rd_burst_cnt  = 0;
    int wr_words_seen = 0;
    int rd_words_seen = 0;
    bit chk_drop_done = 0;
    bit chk_wen_done  = 0;

    task automatic serve();
        logic [APP_AW-1:0] a, wa;
        logic [APP_DW-1:0] d;
        int  l;
        bit  wr;
        a  = app_req_addr;
        l  = int'(app_req_len);
        wr = !app_req_wr_n;
        req_addr.push_back(int'(a));
        req_len.push_back(l);
        req_wr.push_back(int'(wr));
        app_req_ack = 1'b1;
        @(posedge clk); #1;
        app_req_ack = 1'b0;
        if (!reset_n) return;
        if (!chk_drop_done) begin
            check("req_drop_after_ack", app_req, 0);
            chk_drop_done = 1;
        end
        for (int i = 0; i < l; i++) begin
            if (!reset_n) begin
                app_wr_next_req = 1'b0;
                app_rd_valid    = 1'b0;
                return;
            end
            wa = a + APP_AW'(i);
            if (wr) begin
                if (!chk_wen_done) begin
                    check("wr_en_n_in_wr_data", app_wr_en_n, 0);
                    chk_wen_done = 1;
                end
                mem[wa] = app_wr_data;
                app_wr_next_req = 1'b1;
                wr_words_seen++;
                @(posedge clk); #1;
                app_wr_next_req = 1'b0;
                if (i % 2 == 1) begin
                    @(posedge clk); #1;
                end
            end else begin
                d = mem.exists(wa) ? mem[wa] : '0;
                if (rd_burst_cnt == corrupt_burst && i == corrupt_word) d = d ^ 32'h8;
                app_rd_valid = 1'b1;
                app_rd_data  = d;
                rd_words_seen++;
                @(posedge clk); #1;
            end
        end
        app_rd_valid = 1'b0;
        if (!wr) rd_burst_cnt++;
    endtask

    initial begin
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_valid    = 1'b0;
        app_rd_data     = '0;
        forever begin
            @(posedge clk); #1;
            if (reset_n && app_req) serve();
        end
    end

    task automatic clear_log();
        req_addr.delete();
        req_len.delete();
        req_wr.delete();
        mem.delete();
        rd_burst_cnt  = 0;
        wr_words_seen = 0;
        rd_words_seen = 0;
    endtask

    task automatic run_bist(input logic [APP_AW-1:0] base, input logic [APP_AW-1:0] stride,
                            input logic [8:0] len, input logic [15:0] num, input logic [31:0] seed,
                            input int init_delay, input int budget);
        bit finished;
        cfg_base_addr  = base;
        cfg_stride     = stride;
        cfg_len        = len;
        cfg_num_bursts = num;
        cfg_seed       = seed;
        clear_log();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_clear_on_start", done, 0);
        if (init_delay > 0) begin
            repeat (init_delay) @(negedge clk);
            check("no_req_before_init", req_addr.size(), 0);
            sdr_init_done = 1'b1;
        end
        finished = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        if (finished) check("busy_low_at_done", busy, 0);
        else          check("done_timeout", done, 1);
    endtask

    logic [31:0] exp_words [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        exp_words[0] = 32'h1122_3344;
        exp_words[1] = 32'h0891_19A2;
        exp_words[2] = 32'h0448_8CD1;
        exp_words[3] = 32'h8204_466B;
        exp_words[4] = 32'hC122_2336;

        reset_n = 1'b0; start = 1'b0; sdr_init_done = 1'b0; err_inject = 1'b0;
        cfg_base_addr = '0; cfg_stride = '0; cfg_len = '0; cfg_num_bursts = '0; cfg_seed = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_addr, 0);
        check("rst_app_req", app_req, 0);
        check("rst_req_wr_n", app_req_wr_n, 1);
        check("rst_wr_en_n", app_wr_en_n, 4'hF);
        check("rst_wr_data", app_wr_data, 0);
        check("rst_req_addr", app_req_addr, 0);
        check("rst_req_len", app_req_len, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single burst of 5, with init held off for a few cycles.
        run_bist(26'h001_0000, 26'h0, 9'd5, 16'd1, 32'h1122_3344, 4, 500);
        check("t1_pass", pass, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_num_req", req_addr.size(), 2);
        check("t1_wr_addr", req_addr[0], 32'h0001_0000);
        check("t1_len", req_len[0], 5);
        check("t1_dir_wr", req_wr[0], 1);
        check("t1_dir_rd", req_wr[1], 0);
        check("t1_wr_words", wr_words_seen, 5);
        check("t1_rd_words", rd_words_seen, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_word%0d", i), mem[26'h001_0000 + 26'(i)], exp_words[i]);
        end
        check("t1_wr_en_n_idle", app_wr_en_n, 4'hF);

        // Twenty bursts wrapping the top of the address space, zero seed.
        run_bist(26'h3FF_F000, 26'h000_1000, 9'd2, 16'd20, 32'h0, 0, 3000);
        check("t2_pass", pass, 1);
        check("t2_num_req", req_addr.size(), 40);
        check("t2_addr_b0", req_addr[0], 32'h03FF_F000);
        check("t2_addr_b1", req_addr[2], 32'h0000_0000);
        check("t2_addr_b19", req_addr[38], 32'h0001_2000);
        check("t2_zero_seed_w0", mem[26'h3FF_F000], 32'h1);
        check("t2_zero_seed_w1", mem[26'h3FF_F001], 32'h8020_0003);
        check("t2_seed_b1", mem[26'h000_0000], 32'h1);
        check("t2_seed_b2", mem[26'h000_1000], 32'h2);

        // Zero bursts: done two cycles after start, no requests.
        clear_log();
        cfg_num_bursts = 16'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("t3_done_low", done, 0);
        check("t3_busy", busy, 1);
        @(negedge clk);
        check("t3_done", done, 1);
        check("t3_pass", pass, 1);
        check("t3_busy_low", busy, 0);
        check("t3_no_req", req_addr.size(), 0);

        // Corrupt bit 3 of read word 2 of burst 1.
        corrupt_burst = 1;
        corrupt_word  = 2;
        run_bist(26'h0, 26'h000_0100, 9'd4, 16'd2, 32'hA5A5_A5A4, 0, 1000);
        corrupt_burst = -1;
        check("t4_pass", pass, 0);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_first_err", first_err_addr, 26'h000_0102);
        check("t4_seed_b0", mem[26'h000_0000], 32'hA5A5_A5A4);
        check("t4_seed_b1", mem[26'h000_0100], 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        check("t4_done_sticky", done, 1);

        // Length 0 is treated as 1.
        run_bist(26'h000_0200, 26'h0, 9'd0, 16'd1, 32'h5, 0, 500);
        check("t5_pass", pass, 1);
        check("t5_len", req_len[0], 1);
        check("t5_wr_words", wr_words_seen, 1);
        check("t5_word", mem[26'h000_0200], 32'h5);

        // Reset during WR_DATA aborts at once.
        clear_log();
        cfg_base_addr = 26'h000_0040; cfg_stride = '0; cfg_len = 9'd8;
        cfg_num_bursts = 16'd1; cfg_seed = 32'h0BAD_F00D;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (wr_words_seen >= 3) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t6_reached_wr_data", seen, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_app_req", app_req, 0);
        check("t6_rst_wr_en_n", app_wr_en_n, 4'hF);
        check("t6_rst_busy", busy, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_bist(26'h000_0040, 26'h0, 9'd8, 16'd1, 32'h0BAD_F00D, 0, 500);
        check("t6_rerun_pass", pass, 1);
        check("t6_rerun_err", err_cnt, 0);

`ifdef SDRC_BIST_ERR_INJ_EN
        @(negedge clk); err_inject = 1'b1;
        @(negedge clk); err_inject = 1'b0;
        run_bist(26'h000_0300, 26'h0, 9'd8, 16'd1, 32'h1234_5678, 0, 500);
        check("t7_inj_pass", pass, 0);
        check("t7_inj_err", err_cnt, 1);
        check("t7_inj_first", first_err_addr, 26'h000_0300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
